pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain_if.sv | 36 +++
 rtl/pipe_stage_chain.sv | 98 +++++++++
 tb/tb_pipe_stage_chain.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Bundle of all data/control signals of pipe_stage_chain.
// Handshake: a word on data_i/valid_i is captured into stage 0 on a rising
// edge where ready_o = 1 and flush_i[0] = 0; while ready_o = 0 the source
// must keep data_i/valid_i stable, nothing is taken. valid_i = 0 presents a
// bubble, which is loaded like any other word.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]       data_i;
    logic                   valid_i;
    logic [DEPTH-1:0]       stall_i;
    logic [DEPTH-1:0]       flush_i;
    logic                   ready_o;
    logic [WIDTH-1:0]       data_o;
    logic                   valid_o;
    logic [DEPTH*WIDTH-1:0] stage_data_o;
    logic [DEPTH-1:0]       stage_valid_o;
    logic [CNT_W-1:0]       retire_cnt_o;
    logic [CNT_W-1:0]       bubble_cnt_o;

    // Upstream side: hazard/branch logic and the instruction source.
    modport master (
        output data_i, valid_i, stall_i, flush_i,
        input  ready_o, data_o, valid_o, stage_data_o, stage_valid_o,
               retire_cnt_o, bubble_cnt_o
    );

    // The stage chain itself.
    modport slave (
        input  data_i, valid_i, stall_i, flush_i,
        output ready_o, data_o, valid_o, stage_data_o, stage_valid_o,
               retire_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline registers with per-stage stall and flush, valid
// tracking, and saturating retire/bubble counters. Stage 0 takes data_i,
// stage DEPTH-1 drives data_o.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_stage_chain_if.slave bus
);
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    // Effective hold per stage, and what each stage would load if it moved.
    logic [DEPTH-1:0] hold;
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] up_hold;

    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A stall backs up into every earlier stage: hold[k] = |stall_i[DEPTH-1:k].
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = bus.stall_i[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = hold[k+1] | bus.stall_i[k];
        end
    end

    // Upstream source of each stage; stage 0 sees data_i and never an
    // upstream hold, so its "gap bubble" case cannot arise.
    always_comb begin
        up_data[0]  = bus.data_i;
        up_valid[0] = bus.valid_i;
        up_hold[0]  = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            up_data[k]  = stage_data[k-1];
            up_valid[k] = stage_valid[k-1];
            up_hold[k]  = hold[k-1];
        end
    end

    // Stage registers: reset > flush > hold > gap bubble > advance.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst_i || bus.flush_i[k]) begin
                stage_data[k]  <= '0;
                stage_valid[k] <= 1'b0;
            end else if (hold[k]) begin
                stage_data[k]  <= stage_data[k];
                stage_valid[k] <= stage_valid[k];
            end else if (up_hold[k]) begin
                stage_data[k]  <= '0;
                stage_valid[k] <= 1'b0;
            end else begin
                stage_data[k]  <= up_data[k];
                stage_valid[k] <= up_valid[k];
            end
        end
    end

    // Saturating statistics: retire when the output entry leaves, bubble
    // whenever the output stage is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stage_valid[DEPTH-1] && !bus.stall_i[DEPTH-1] && retire_cnt != CNT_MAX) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (!stage_valid[DEPTH-1] && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    // Flatten stage state onto the observation buses.
    always_comb begin
        bus.stage_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.stage_data_o[k*WIDTH +: WIDTH] = stage_data[k];
        end
    end

    assign bus.stage_valid_o = stage_valid;
    assign bus.data_o        = stage_data[DEPTH-1];
    assign bus.valid_o       = stage_valid[DEPTH-1];
    assign bus.ready_o       = !hold[0];
    assign bus.retire_cnt_o  = retire_cnt;
    assign bus.bubble_cnt_o  = bubble_cnt;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a WIDTH=8/DEPTH=4 chain with 16-bit
// counters, plus a twin with 4-bit counters fed the same inputs to exercise
// saturation.
module tb_pipe_stage_chain;
    localparam int W = 8;
    localparam int D = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) bus ();
    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D), .CNT_W(4))  bus_s ();

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_s)
    );

    assign bus_s.data_i  = bus.data_i;
    assign bus_s.valid_i = bus.valid_i;
    assign bus_s.stall_i = bus.stall_i;
    assign bus_s.flush_i = bus.flush_i;

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic [D-1:0] st, input logic [D-1:0] fl);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.stall_i = st;
        bus.flush_i = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'hFF, 4'b0000, 4'b0000);
        tick();
        tick();
        n_cmp++; if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data_o: got %h want 00", bus.data_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.stage_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_stage_data: got %h want 0", bus.stage_data_o); end
        n_cmp++; if (bus.stage_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_stage_valid: got %b want 0000", bus.stage_valid_o); end
        n_cmp++; if (bus.retire_cnt_o !== 16'd0 || bus.bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.retire_cnt_o, bus.bubble_cnt_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        bus.stall_i = 4'b0100;
        #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_stalled: got %b want 0", bus.ready_o); end
        bus.stall_i = 4'b0000;
    endtask

    task automatic test_stream();
        rst = 1'b0;
        drive(1'b1, 8'h11, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h22, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h33, 4'b0000, 4'b0000); tick();
        drive(1'b0, 8'h00, 4'b0000, 4'b0000);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_early: valid_o got %b want 0", bus.valid_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h11) begin n_fail++; $display("FAIL stream_w0: got %b/%h want 1/11", bus.valid_o, bus.data_o); end
        n_cmp++; if (bus.bubble_cnt_o !== 16'd4) begin n_fail++; $display("FAIL stream_bubble4: got %0d want 4", bus.bubble_cnt_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h22) begin n_fail++; $display("FAIL stream_w1: got %b/%h want 1/22", bus.valid_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h33) begin n_fail++; $display("FAIL stream_w2: got %b/%h want 1/33", bus.valid_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b0 || bus.data_o !== 8'h00) begin n_fail++; $display("FAIL stream_tail: got %b/%h want 0/00", bus.valid_o, bus.data_o); end
        n_cmp++; if (bus.retire_cnt_o !== 16'd3) begin n_fail++; $display("FAIL stream_retire: got %0d want 3", bus.retire_cnt_o); end
        n_cmp++; if (bus.bubble_cnt_o !== 16'd4) begin n_fail++; $display("FAIL stream_bubble_hold: got %0d want 4", bus.bubble_cnt_o); end
        tick();
        n_cmp++; if (bus.bubble_cnt_o !== 16'd5) begin n_fail++; $display("FAIL stream_bubble5: got %0d want 5", bus.bubble_cnt_o); end
    endtask

    task automatic test_mid_stall();
        drive(1'b1, 8'h11, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h22, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h33, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h44, 4'b0010, 4'b0000);
        #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b want 0", bus.ready_o); end
        tick();
        n_cmp++; if (bus.stage_valid_o !== 4'b1011) begin n_fail++; $display("FAIL stall_valid: got %b want 1011", bus.stage_valid_o); end
        n_cmp++; if (bus.stage_data_o !== 32'h1100_2233) begin n_fail++; $display("FAIL stall_data: got %h want 11002233", bus.stage_data_o); end
        drive(1'b1, 8'h44, 4'b0000, 4'b0000); tick();
        n_cmp++; if (bus.valid_o !== 1'b0 || bus.data_o !== 8'h00) begin n_fail++; $display("FAIL stall_out_bubble: got %b/%h want 0/00", bus.valid_o, bus.data_o); end
        drive(1'b0, 8'h00, 4'b0000, 4'b0000); tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h22) begin n_fail++; $display("FAIL stall_out_22: got %b/%h want 1/22", bus.valid_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h33) begin n_fail++; $display("FAIL stall_out_33: got %b/%h want 1/33", bus.valid_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h44) begin n_fail++; $display("FAIL stall_out_44: got %b/%h want 1/44", bus.valid_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.stage_valid_o !== 4'b0000) begin n_fail++; $display("FAIL stall_drained: got %b want 0000", bus.stage_valid_o); end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'h11, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h22, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h33, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h44, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'h55, 4'b0001, 4'b0011);
        #1;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.ready_o); end
        tick();
        n_cmp++; if (bus.stage_valid_o !== 4'b1100) begin n_fail++; $display("FAIL flush_valid: got %b want 1100", bus.stage_valid_o); end
        n_cmp++; if (bus.stage_data_o !== 32'h2233_0000) begin n_fail++; $display("FAIL flush_data: got %h want 22330000", bus.stage_data_o); end
        drive(1'b1, 8'h66, 4'b0000, 4'b0001); tick();
        n_cmp++; if (bus.stage_valid_o !== 4'b1000 || bus.stage_data_o !== 32'h3300_0000) begin n_fail++; $display("FAIL flush_drop_input: got %b/%h want 1000/33000000", bus.stage_valid_o, bus.stage_data_o); end
        drive(1'b0, 8'h00, 4'b0000, 4'b0000);
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        drive(1'b0, 8'h00, 4'b0000, 4'b0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        n_cmp++; if (bus_s.bubble_cnt_o !== 4'd14) begin n_fail++; $display("FAIL sat_bubble14: got %0d want 14", bus_s.bubble_cnt_o); end
        tick();
        n_cmp++; if (bus_s.bubble_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_bubble15: got %0d want 15", bus_s.bubble_cnt_o); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (bus_s.bubble_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_bubble_stay: got %0d want 15", bus_s.bubble_cnt_o); end
        n_cmp++; if (bus_s.retire_cnt_o !== 4'd0) begin n_fail++; $display("FAIL sat_retire: got %0d want 0", bus_s.retire_cnt_o); end
        n_cmp++; if (bus.bubble_cnt_o !== 16'd20) begin n_fail++; $display("FAIL sat_wide_bubble: got %0d want 20", bus.bubble_cnt_o); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hA1, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'hA2, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'hA3, 4'b0000, 4'b0000); tick();
        drive(1'b1, 8'hA4, 4'b0000, 4'b0000); tick();
        drive(1'b0, 8'h00, 4'b1000, 4'b0000); tick();
        n_cmp++; if (bus.stage_valid_o !== 4'b1111 || bus.stage_data_o !== 32'hA1A2_A3A4) begin n_fail++; $display("FAIL hold_all: got %b/%h want 1111/a1a2a3a4", bus.stage_valid_o, bus.stage_data_o); end
        n_cmp++; if (bus.retire_cnt_o !== 16'd0 || bus.bubble_cnt_o !== 16'd24) begin n_fail++; $display("FAIL hold_counters: got %0d/%0d want 0/24", bus.retire_cnt_o, bus.bubble_cnt_o); end
        rst = 1'b1;
        drive(1'b1, 8'hA5, 4'b1000, 4'b0000); tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 4'b0000, 4'b0000);
        n_cmp++; if (bus.stage_valid_o !== 4'b0000 || bus.stage_data_o !== 32'h0) begin n_fail++; $display("FAIL midrst_stages: got %b/%h want 0000/0", bus.stage_valid_o, bus.stage_data_o); end
        n_cmp++; if (bus.retire_cnt_o !== 16'd0 || bus.bubble_cnt_o !== 16'd0 || bus_s.bubble_cnt_o !== 4'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d/%0d/%0d want 0/0/0", bus.retire_cnt_o, bus.bubble_cnt_o, bus_s.bubble_cnt_o); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 8'h00, 4'b0000, 4'b0000);
        test_reset();
        test_stream();
        test_mid_stall();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
